// File: rtl/flappy_game_ctrl.sv
// flappy_game_ctrl: IDLE/PLAY/DYING/OVER sequencer with flap pulse, saturating BCD score and high score.
module flappy_game_ctrl #(
  parameter int SCORE_DIGITS = 4,
  parameter int DEATH_TICKS  = 60
) (
  input  logic                      gameClk,
  input  logic                      reset,
  input  logic                      btn_in,
  input  logic                      hit_column,
  input  logic                      pass_column,
  output logic                      flap,
  output logic                      freeze,
  output logic [1:0]                state,
  output logic [4*SCORE_DIGITS-1:0] score_bcd,
  output logic [4*SCORE_DIGITS-1:0] high_bcd,
  output logic                      new_high
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] PLAY  = 2'd1;
  localparam logic [1:0] DYING = 2'd2;
  localparam logic [1:0] OVER  = 2'd3;
  localparam int SW = 4 * SCORE_DIGITS;
  localparam int CW = DEATH_TICKS > 1 ? $clog2(DEATH_TICKS) : 1;
  logic s1_q, s2_q, s3_q, btn_edge;
  logic [1:0] state_q, state_d;
  logic [SW-1:0] score_q, score_d, high_q, high_d, score_inc;
  logic [CW-1:0] cnt_q, cnt_d;
  logic flap_q, flap_d, freeze_q, new_high_q, new_high_d;
  logic carry;
  logic score_sat;
  assign btn_edge  = s2_q & ~s3_q;
  assign score_sat = score_q == {SCORE_DIGITS{4'h9}};
  // Ripple BCD increment: a digit advances only while every lower digit wraps from 9.
  always_comb begin
    score_inc = score_q;
    carry = 1'b1;
    for (int i = 0; i < SCORE_DIGITS; i++) begin
      score_inc[4*i+:4] = carry ? (score_q[4*i+:4] == 4'd9 ? 4'd0 : score_q[4*i+:4] + 4'd1) : score_q[4*i+:4];
      carry = carry & (score_q[4*i+:4] == 4'd9);
    end
  end
  always_comb begin
    state_d    = state_q;
    score_d    = score_q;
    high_d     = high_q;
    cnt_d      = cnt_q;
    flap_d     = 1'b0;
    new_high_d = 1'b0;
    if (state_q == IDLE) begin
      state_d = btn_edge ? PLAY : IDLE;
      score_d = btn_edge ? '0 : score_q;
      flap_d  = btn_edge;
    end else if (state_q == PLAY) begin
      flap_d  = btn_edge;
      state_d = hit_column ? DYING : PLAY;
      cnt_d   = hit_column ? '0 : cnt_q;
      score_d = (!hit_column && pass_column && !score_sat) ? score_inc : score_q;
    end else if (state_q == DYING) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == CW'(DEATH_TICKS - 1)) begin
        state_d    = OVER;
        new_high_d = score_q > high_q;
        high_d     = score_q > high_q ? score_q : high_q;
      end
    end else begin
      state_d = btn_edge ? IDLE : OVER;
    end
  end
  always_ff @(posedge gameClk) begin
    if (reset) begin
      s1_q       <= 1'b0;
      s2_q       <= 1'b0;
      s3_q       <= 1'b0;
      state_q    <= IDLE;
      score_q    <= '0;
      high_q     <= '0;
      cnt_q      <= '0;
      flap_q     <= 1'b0;
      freeze_q   <= 1'b1;
      new_high_q <= 1'b0;
    end else begin
      s1_q       <= btn_in;
      s2_q       <= s1_q;
      s3_q       <= s2_q;
      state_q    <= state_d;
      score_q    <= score_d;
      high_q     <= high_d;
      cnt_q      <= cnt_d;
      flap_q     <= flap_d;
      freeze_q   <= state_d != PLAY;
      new_high_q <= new_high_d;
    end
  end
  assign flap      = flap_q;
  assign freeze    = freeze_q;
  assign state     = state_q;
  assign score_bcd = score_q;
  assign high_bcd  = high_q;
  assign new_high  = new_high_q;
endmodule

// File: tb/tb_flappy_game_ctrl.sv
// tb_flappy_game_ctrl: directed checks of start latency, BCD scoring, death timing and high score.
module tb_flappy_game_ctrl;
  localparam int SD = 4;
  localparam int DT = 6;
  logic gameClk = 1'b0;
  logic reset, btn_in, hit_column, pass_column;
  logic flap, freeze, new_high;
  logic [1:0] state;
  logic [4*SD-1:0] score_bcd, high_bcd;
  int errors = 0;
  int checks = 0;
  int flaps, highs;
  flappy_game_ctrl #(.SCORE_DIGITS(SD), .DEATH_TICKS(DT)) dut (
    .gameClk(gameClk), .reset(reset), .btn_in(btn_in), .hit_column(hit_column),
    .pass_column(pass_column), .flap(flap), .freeze(freeze), .state(state),
    .score_bcd(score_bcd), .high_bcd(high_bcd), .new_high(new_high)
  );
  always #5 gameClk = ~gameClk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge gameClk);
    #1;
  endtask
  task automatic press();
    btn_in = 1'b1;
    repeat (3) tick();
  endtask
  task automatic release_btn();
    btn_in = 1'b0;
    repeat (3) tick();
  endtask
  task automatic passes(input int n);
    repeat (n) begin
      pass_column = 1'b1;
      tick();
    end
    pass_column = 1'b0;
  endtask
  task automatic do_reset();
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
  endtask
  initial begin
    btn_in = 1'b0; hit_column = 1'b0; pass_column = 1'b0;
    do_reset();
    chk("rst_state", state, 0);
    chk("rst_freeze", freeze, 1);
    chk("rst_score", score_bcd, 0);
    chk("rst_high", high_bcd, 0);
    chk("rst_flap", flap, 0);
    chk("rst_new_high", new_high, 0);
    hit_column = 1'b1; pass_column = 1'b1;
    tick();
    hit_column = 1'b0; pass_column = 1'b0;
    chk("idle_ignore_state", state, 0);
    chk("idle_ignore_score", score_bcd, 0);
    btn_in = 1'b1;
    tick();
    chk("lat_e0_state", state, 0);
    tick();
    chk("lat_e1_state", state, 0);
    chk("lat_e1_flap", flap, 0);
    tick();
    chk("start_state", state, 1);
    chk("start_freeze", freeze, 0);
    chk("start_flap", flap, 1);
    flaps = 0;
    repeat (5) begin
      tick();
      flaps += int'(flap);
    end
    chk("held_no_flap", flaps, 0);
    release_btn();
    press();
    chk("play_flap", flap, 1);
    chk("play_flap_state", state, 1);
    release_btn();
    passes(123);
    chk("score_123", score_bcd, 32'h0123);
    passes(9876);
    chk("score_9999", score_bcd, 32'h9999);
    passes(1);
    chk("score_sat", score_bcd, 32'h9999);
    do_reset();
    chk("rst2_state", state, 0);
    chk("rst2_score", score_bcd, 0);
    press();
    release_btn();
    passes(7);
    chk("score_7", score_bcd, 32'h0007);
    hit_column = 1'b1; pass_column = 1'b1;
    tick();
    hit_column = 1'b0; pass_column = 1'b0;
    chk("hit_state", state, 2);
    chk("hit_score", score_bcd, 32'h0007);
    chk("hit_freeze", freeze, 1);
    highs = 0;
    repeat (DT - 1) begin
      tick();
      highs += int'(new_high);
    end
    chk("dying_dwell_state", state, 2);
    chk("dying_no_new_high", highs, 0);
    tick();
    chk("over_state", state, 3);
    chk("over_high", high_bcd, 32'h0007);
    chk("over_new_high", new_high, 1);
    chk("over_score", score_bcd, 32'h0007);
    tick();
    chk("new_high_once", new_high, 0);
    press();
    chk("over_to_idle", state, 0);
    chk("over_no_flap", flap, 0);
    chk("idle_score_held", score_bcd, 32'h0007);
    release_btn();
    press();
    chk("game3_score_clr", score_bcd, 0);
    release_btn();
    passes(5);
    hit_column = 1'b1;
    tick();
    hit_column = 1'b0;
    btn_in = 1'b1;
    flaps = 0; highs = 0;
    repeat (DT) begin
      tick();
      flaps += int'(flap);
      highs += int'(new_high);
    end
    chk("dying_btn_no_flap", flaps, 0);
    chk("low_state_over", state, 3);
    chk("low_high_kept", high_bcd, 32'h0007);
    chk("low_no_new_high", highs, 0);
    release_btn();
    chk("dying_btn_ignored", state, 3);
    press();
    chk("over_btn_idle", state, 0);
    release_btn();
    press();
    release_btn();
    passes(42);
    chk("score_42", score_bcd, 32'h0042);
    hit_column = 1'b1;
    tick();
    hit_column = 1'b0;
    repeat (2) tick();
    chk("mid_dying", state, 2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_state", state, 0);
    chk("abort_high", high_bcd, 0);
    chk("abort_new_high", new_high, 0);
    chk("abort_freeze", freeze, 1);
    highs = 0;
    repeat (DT + 2) begin
      tick();
      highs += int'(new_high);
    end
    chk("abort_no_pulse", highs, 0);
    chk("abort_stays_idle", state, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
